// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the fetch redirect unit and the hazard unit.
//   pc_sel_t      : next-PC source select driven by the hazard unit
//   fetch_state_t : fetch FSM states
//   OPC_*         : control-transfer opcodes that the hazard unit decodes
// No ports (package).
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_JALR   = 2'b01,
    PC_BRANCH = 2'b10,
    PC_JAL    = 2'b11
  } pc_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    HOLD = 2'b11
  } fetch_state_t;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/if_de_pipe_reg.sv
// -----------------------------------------------------------------------------
// if_de_pipe_reg
// IF/DE pipeline register: valid bit, PC, PC+4 and instruction word.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   stall             : decode cannot accept; contents held
//   flush             : kill whatever sits in / enters the register this cycle
//   load              : a new instruction is presented on load_pc/load_ir
//   load_pc, load_ir  : PC and instruction word of the new instruction
//   valid, pc, pc4, ir: registered IF/DE contents
// -----------------------------------------------------------------------------
module if_de_pipe_reg #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            load,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_ir,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc4,
  output logic [XLEN-1:0] ir
);

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  // Flush kills the valid bit even while stalled; the data fields stay put
  // so decode sees a stable (but dead) word.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= '0;
      pc4   <= '0;
      ir    <= '0;
    end else if (stall) begin
      if (flush) valid <= 1'b0;
    end else if (load) begin
      valid <= ~flush;
      pc    <= load_pc;
      pc4   <= load_pc + FOUR;
      ir    <= load_ir;
    end else begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// -----------------------------------------------------------------------------
// fetch_redirect_unit
// Owns the architectural PC, issues single-outstanding instruction fetches,
// applies redirects/flush from the hazard unit, squashes stale responses and
// drives the IF/DE register. A one-entry hold buffer absorbs a response that
// arrives while decode is stalled.
// Optional feature: define FETCH_PERF_EN to add perf_redirects/perf_squashed.
// Ports:
//   CLK, RST                    : clock, synchronous active-high reset
//   stall, flush                : decode back-pressure, IF/DE kill
//   pc_sel                      : 00 PC+4, 01 jalr, 10 branch, 11 jal
//   jalr_pc, branch_pc, jal_pc  : redirect targets
//   imem_req, imem_addr         : fetch request / address (= pc)
//   imem_gnt, imem_rvalid,
//   imem_rdata                  : memory grant and response
//   if_de_valid, if_de_pc,
//   if_de_pc4, if_de_ir         : IF/DE register outputs
//   perf_redirects,
//   perf_squashed               : event counters (FETCH_PERF_EN only)
// -----------------------------------------------------------------------------
module fetch_redirect_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            stall,
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] jalr_pc,
  input  logic [XLEN-1:0] branch_pc,
  input  logic [XLEN-1:0] jal_pc,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
`ifdef FETCH_PERF_EN
  output logic [31:0]     perf_redirects,
  output logic [31:0]     perf_squashed,
`endif
  output logic            if_de_valid,
  output logic [XLEN-1:0] if_de_pc,
  output logic [XLEN-1:0] if_de_pc4,
  output logic [XLEN-1:0] if_de_ir
);

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic            squash;
  logic            req_q;
  logic [XLEN-1:0] hold_pc;
  logic [XLEN-1:0] hold_ir;

  pc_sel_t         sel;
  logic            redirect;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_plus4;

  logic            pipe_load;
  logic [XLEN-1:0] pipe_pc;
  logic [XLEN-1:0] pipe_ir;
  logic            discard;
  logic            drop_hold;

  assign sel       = pc_sel_t'(pc_sel);
  assign redirect  = (sel != PC_PLUS4);
  assign pc_plus4  = pc + FOUR;
  assign imem_req  = req_q;
  assign imem_addr = pc;

  always_comb begin
    target = pc_plus4;
    unique case (sel)
      PC_JALR:   target = jalr_pc;
      PC_BRANCH: target = branch_pc;
      PC_JAL:    target = jal_pc;
      default:   target = pc_plus4;
    endcase
  end

  // A response is usable only if it is not squashed and no redirect is
  // arriving in the same cycle; redirect outranks stall.
  always_comb begin
    pipe_load = 1'b0;
    pipe_pc   = pc;
    pipe_ir   = imem_rdata;
    discard   = 1'b0;
    drop_hold = 1'b0;
    unique case (state)
      WAIT: begin
        if (imem_rvalid) begin
          if (squash || redirect) discard = 1'b1;
          else if (!stall)        pipe_load = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          drop_hold = 1'b1;
        end else if (!stall) begin
          pipe_load = 1'b1;
          pipe_pc   = hold_pc;
          pipe_ir   = hold_ir;
        end
      end
      default: ;
    endcase
  end

  // Fetch FSM. imem_req is registered: it is set whenever the next state is REQ.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      pc      <= RESET_VEC;
      squash  <= 1'b0;
      req_q   <= 1'b0;
      hold_pc <= '0;
      hold_ir <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (redirect) pc <= target;
          state <= REQ;
          req_q <= 1'b1;
        end
        REQ: begin
          if (redirect) pc <= target;
          if (imem_gnt) begin
            // Memory accepted the old address, so its response must be dropped.
            squash <= redirect;
            state  <= WAIT;
            req_q  <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            squash <= 1'b0;
            state  <= REQ;
            req_q  <= 1'b1;
            if (redirect) begin
              pc <= target;
            end else if (!squash) begin
              pc <= pc_plus4;
              if (stall) begin
                hold_pc <= pc;
                hold_ir <= imem_rdata;
                state   <= HOLD;
                req_q   <= 1'b0;
              end
            end
          end else if (redirect) begin
            pc     <= target;
            squash <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc    <= target;
            state <= REQ;
            req_q <= 1'b1;
          end else if (!stall) begin
            state <= REQ;
            req_q <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_redirects <= '0;
      perf_squashed  <= '0;
    end else begin
      if (redirect)              perf_redirects <= perf_redirects + 32'd1;
      if (discard || drop_hold)  perf_squashed  <= perf_squashed + 32'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = discard ^ drop_hold;
`endif

  if_de_pipe_reg #(.XLEN(XLEN)) u_if_de (
    .clk     (CLK),
    .rst     (RST),
    .stall   (stall),
    .flush   (flush),
    .load    (pipe_load),
    .load_pc (pipe_pc),
    .load_ir (pipe_ir),
    .valid   (if_de_valid),
    .pc      (if_de_pc),
    .pc4     (if_de_pc4),
    .ir      (if_de_ir)
  );

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_redirect_unit
// Directed self-checking bench for fetch_redirect_unit. The memory side is
// driven by hand, cycle by cycle. Define FETCH_PERF_EN to also check counters.
// -----------------------------------------------------------------------------
module tb_fetch_redirect_unit;

  logic        CLK;
  logic        RST;
  logic        stall;
  logic [1:0]  pc_sel;
  logic [31:0] jalr_pc;
  logic [31:0] branch_pc;
  logic [31:0] jal_pc;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_de_valid;
  logic [31:0] if_de_pc;
  logic [31:0] if_de_pc4;
  logic [31:0] if_de_ir;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_redirects;
  logic [31:0] perf_squashed;
`endif

  int errors = 0;
  int checks = 0;

  fetch_redirect_unit #(.XLEN(32), .RESET_VEC(32'h0000_0000)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .stall       (stall),
    .pc_sel      (pc_sel),
    .jalr_pc     (jalr_pc),
    .branch_pc   (branch_pc),
    .jal_pc      (jal_pc),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
`ifdef FETCH_PERF_EN
    .perf_redirects (perf_redirects),
    .perf_squashed  (perf_squashed),
`endif
    .if_de_valid (if_de_valid),
    .if_de_pc    (if_de_pc),
    .if_de_pc4   (if_de_pc4),
    .if_de_ir    (if_de_ir)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive inputs for the coming edge, then step to 1 time unit past that edge.
  task automatic applyStimulus(input logic g, input logic rv, input logic [31:0] rd,
                               input logic [1:0] sel, input logic st, input logic fl);
    imem_gnt    = g;
    imem_rvalid = rv;
    imem_rdata  = rd;
    pc_sel      = sel;
    stall       = st;
    flush       = fl;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    RST = 1'b1;
    jalr_pc = '0; branch_pc = '0; jal_pc = '0;
    applyStimulus(0, 0, 0, 2'b00, 0, 0);
    applyStimulus(0, 0, 0, 2'b00, 0, 0);
    checkOutput("rst_req",   {31'd0, imem_req},    32'd0);
    checkOutput("rst_addr",  imem_addr,            32'h0);
    checkOutput("rst_valid", {31'd0, if_de_valid}, 32'd0);
    checkOutput("rst_pc",    if_de_pc,             32'h0);
    checkOutput("rst_pc4",   if_de_pc4,            32'h0);
    checkOutput("rst_ir",    if_de_ir,             32'h0);
`ifdef FETCH_PERF_EN
    checkOutput("rst_perf_redir", perf_redirects, 32'd0);
    checkOutput("rst_perf_squash", perf_squashed, 32'd0);
`endif

    // IDLE -> REQ at RESET_VEC, immediate grant, response one cycle later
    RST = 1'b0;
    applyStimulus(0, 0, 0, 2'b00, 0, 0);
    checkOutput("req0_req",  {31'd0, imem_req}, 32'd1);
    checkOutput("req0_addr", imem_addr,         32'h0);
    applyStimulus(1, 0, 0, 2'b00, 0, 0);
    checkOutput("wait0_req", {31'd0, imem_req}, 32'd0);
    applyStimulus(0, 1, 32'h0000_0013, 2'b00, 0, 0);
    checkOutput("ld0_valid", {31'd0, if_de_valid}, 32'd1);
    checkOutput("ld0_pc",    if_de_pc,             32'h0);
    checkOutput("ld0_ir",    if_de_ir,             32'h0000_0013);
    checkOutput("ld0_pc4",   if_de_pc4,            32'h4);
    checkOutput("ld0_req",   {31'd0, imem_req},    32'd1);
    checkOutput("ld0_addr",  imem_addr,            32'h4);

    applyStimulus(1, 0, 0, 2'b00, 0, 0);
    checkOutput("bubble_valid", {31'd0, if_de_valid}, 32'd0);
    applyStimulus(0, 1, 32'h0010_0093, 2'b00, 0, 0);
    checkOutput("ld4_pc",   if_de_pc,  32'h4);
    checkOutput("ld4_addr", imem_addr, 32'h8);

    // Branch while waiting at pc=8; response two cycles later is stale
    branch_pc = 32'h40;
    applyStimulus(1, 0, 0, 2'b00, 0, 0);
    applyStimulus(0, 0, 0, 2'b10, 0, 0);
    checkOutput("br_wait_addr", imem_addr,         32'h40);
    checkOutput("br_wait_req",  {31'd0, imem_req}, 32'd0);
    applyStimulus(0, 0, 0, 2'b00, 0, 0);
    checkOutput("br_still_wait", {31'd0, imem_req}, 32'd0);
    applyStimulus(0, 1, 32'hDEAD_BEEF, 2'b00, 0, 0);
    checkOutput("br_sq_valid", {31'd0, if_de_valid}, 32'd0);
    checkOutput("br_sq_req",   {31'd0, imem_req},    32'd1);
    checkOutput("br_sq_addr",  imem_addr,            32'h40);

    // JAL in the same cycle as the response
    jal_pc = 32'h100;
    applyStimulus(1, 0, 0, 2'b00, 0, 0);
    applyStimulus(0, 1, 32'h1234_5678, 2'b11, 0, 0);
    checkOutput("jal_valid", {31'd0, if_de_valid}, 32'd0);
    checkOutput("jal_req",   {31'd0, imem_req},    32'd1);
    checkOutput("jal_addr",  imem_addr,            32'h100);

    // Redirects while requesting: without grant, then with grant
    jalr_pc = 32'h200;
    applyStimulus(0, 0, 0, 2'b01, 0, 0);
    checkOutput("req_jalr_req",  {31'd0, imem_req}, 32'd1);
    checkOutput("req_jalr_addr", imem_addr,         32'h200);
    branch_pc = 32'hC;
    applyStimulus(1, 0, 0, 2'b10, 0, 0);
    checkOutput("req_br_gnt_req",  {31'd0, imem_req}, 32'd0);
    checkOutput("req_br_gnt_addr", imem_addr,         32'hC);
    applyStimulus(0, 1, 32'hCAFE_F00D, 2'b00, 0, 0);
    checkOutput("req_br_sq_valid", {31'd0, if_de_valid}, 32'd0);
    checkOutput("req_br_sq_addr",  imem_addr,            32'hC);

    // Response at pc=12 under a 3-cycle stall goes to the hold buffer
    applyStimulus(1, 0, 0, 2'b00, 0, 0);
    applyStimulus(0, 1, 32'h0020_8133, 2'b00, 1, 0);
    checkOutput("hold_req",    {31'd0, imem_req}, 32'd0);
    checkOutput("hold_frz_pc", if_de_pc,          32'h4);
    applyStimulus(0, 0, 0, 2'b00, 1, 0);
    applyStimulus(0, 0, 0, 2'b00, 1, 0);
    checkOutput("hold_frz_ir", if_de_ir, 32'h0010_0093);
    applyStimulus(0, 0, 0, 2'b00, 0, 0);
    checkOutput("hold_rel_valid", {31'd0, if_de_valid}, 32'd1);
    checkOutput("hold_rel_pc",    if_de_pc,             32'hC);
    checkOutput("hold_rel_pc4",   if_de_pc4,            32'h10);
    checkOutput("hold_rel_ir",    if_de_ir,             32'h0020_8133);
    checkOutput("hold_rel_addr",  imem_addr,            32'h10);

    // Flush under stall kills IF/DE but the hold entry survives
    applyStimulus(1, 0, 0, 2'b00, 0, 0);
    applyStimulus(0, 1, 32'hAAAA_0001, 2'b00, 0, 0);
    checkOutput("ld16_pc",   if_de_pc,  32'h10);
    checkOutput("ld16_addr", imem_addr, 32'h14);
    applyStimulus(1, 0, 0, 2'b00, 1, 0);
    checkOutput("stall_frz_valid", {31'd0, if_de_valid}, 32'd1);
    checkOutput("stall_frz_pc",    if_de_pc,             32'h10);
    applyStimulus(0, 1, 32'hBBBB_0002, 2'b00, 1, 1);
    checkOutput("flush_valid", {31'd0, if_de_valid}, 32'd0);
    checkOutput("flush_pc",    if_de_pc,             32'h10);
    applyStimulus(0, 0, 0, 2'b00, 1, 0);
    applyStimulus(0, 0, 0, 2'b00, 0, 0);
    checkOutput("survive_valid", {31'd0, if_de_valid}, 32'd1);
    checkOutput("survive_pc",    if_de_pc,             32'h14);
    checkOutput("survive_ir",    if_de_ir,             32'hBBBB_0002);
    checkOutput("survive_addr",  imem_addr,            32'h18);

    // Redirect in HOLD (still stalled) drops the entry
    applyStimulus(1, 0, 0, 2'b00, 0, 0);
    applyStimulus(0, 1, 32'hCCCC_0003, 2'b00, 1, 0);
    jalr_pc = 32'hFFFF_FFFC;
    applyStimulus(0, 0, 0, 2'b01, 1, 0);
    checkOutput("drop_req",  {31'd0, imem_req}, 32'd1);
    checkOutput("drop_addr", imem_addr,         32'hFFFF_FFFC);
    checkOutput("drop_frz_pc", if_de_pc,        32'h14);

    // Fetch at the top of the address space wraps to zero
    applyStimulus(1, 0, 0, 2'b00, 0, 0);
    checkOutput("drop_no_load", {31'd0, if_de_valid}, 32'd0);
    applyStimulus(0, 1, 32'hDDDD_0004, 2'b00, 0, 0);
    checkOutput("wrap_valid", {31'd0, if_de_valid}, 32'd1);
    checkOutput("wrap_pc",    if_de_pc,             32'hFFFF_FFFC);
    checkOutput("wrap_pc4",   if_de_pc4,            32'h0);
    checkOutput("wrap_addr",  imem_addr,            32'h0);
`ifdef FETCH_PERF_EN
    checkOutput("perf_redir",  perf_redirects, 32'd5);
    checkOutput("perf_squash", perf_squashed,  32'd4);
`endif

    // Reset while waiting; the late response must be ignored, and a
    // redirect in IDLE sets the first fetch address
    applyStimulus(1, 0, 0, 2'b00, 0, 0);
    RST = 1'b1;
    applyStimulus(0, 0, 0, 2'b00, 0, 0);
    checkOutput("rst2_req",   {31'd0, imem_req},    32'd0);
    checkOutput("rst2_valid", {31'd0, if_de_valid}, 32'd0);
    RST = 1'b0;
    jalr_pc = 32'h80;
    applyStimulus(0, 1, 32'hEEEE_0005, 2'b01, 0, 0);
    checkOutput("idle_redir_req",   {31'd0, imem_req},    32'd1);
    checkOutput("idle_redir_addr",  imem_addr,            32'h80);
    checkOutput("late_rsp_valid",   {31'd0, if_de_valid}, 32'd0);
`ifdef FETCH_PERF_EN
    checkOutput("perf_redir_after_rst",  perf_redirects, 32'd1);
    checkOutput("perf_squash_after_rst", perf_squashed,  32'd0);
`endif
    applyStimulus(1, 0, 0, 2'b00, 0, 0);
    applyStimulus(0, 0, 0, 2'b00, 0, 0);
    checkOutput("post_rst_wait_req", {31'd0, imem_req},    32'd0);
    checkOutput("post_rst_valid",    {31'd0, if_de_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- Fetch-side consumer of the control-hazard redirect/flush interface.
- Owns the architectural PC, issues instruction-memory fetches (one outstanding), applies pc_sel/target redirects and flush, and drives the IF/DE pipeline register.
- Stale in-flight fetch responses are squashed after a redirect. Decode-stage stall is honoured by a one-entry hold buffer.

Parameters:
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, address/instruction width.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- stall  in  1  decode cannot accept; hold IF/DE.
- pc_sel  in  2  00 PC+4, 01 jalr_pc, 10 branch_pc, 11 jal_pc; stable across posedge.
- jalr_pc  in  XLEN  jalr target.
- branch_pc  in  XLEN  branch target.
- jal_pc  in  XLEN  jal target.
- flush  in  1  kill instruction entering IF/DE this cycle.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address (= pc).
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; at least 1 cycle after gnt.
- imem_rdata  in  XLEN  fetched instruction.
- if_de_valid  out  1  IF/DE holds a live instruction.
- if_de_pc  out  XLEN  PC of IF/DE instruction.
- if_de_pc4  out  XLEN  if_de_pc+4.
- if_de_ir  out  XLEN  instruction word.

Behaviour:
- Reset (RST=1 at posedge):
  - pc=RESET_VEC, state=IDLE, squash=0, imem_req=0.
  - if_de_valid=0; if_de_pc, if_de_pc4 and if_de_ir = 0.
- redirect = (pc_sel!=00). Target is selected by pc_sel. Targets and PC+4 are XLEN-bit modulo (wrap at 2^XLEN).
- States:
  - IDLE: imem_req=0. Next cycle goes to REQ. A redirect in IDLE loads pc=target.
  - REQ: imem_req=1, imem_addr=pc. Go to WAIT on gnt.
    - Redirect with no gnt: pc=target, stay REQ.
    - Redirect with gnt: pc=target, squash=1, go to WAIT.
  - WAIT: imem_req=0.
    - rvalid with squash=1: discard, squash=0, go to REQ.
    - rvalid with squash=0 and stall=0: load IF/DE (valid=!flush). pc=redirect?target:pc+4. Go to REQ.
    - rvalid with squash=0 and stall=1: capture into hold buffer, go to HOLD. pc advances as above.
    - Redirect with no rvalid: pc=target, squash=1.
    - Redirect with rvalid in the same cycle: response discarded, pc=target, go to REQ.
  - HOLD: imem_req=0. When stall=0: load IF/DE from hold buffer, go to REQ.
    - Redirect: drop hold buffer, pc=target, go to REQ.
- IF/DE register:
  - stall=1 holds all IF/DE outputs unchanged.
  - flush=1 (regardless of stall) clears if_de_valid next cycle.
  - When no new instruction loads and stall=0, if_de_valid=0 (bubble).
- Priority: RST > redirect > stall > normal advance.
- Latency: gnt-to-IF/DE is (rvalid cycle)+1. The best case is one instruction every 2 cycles (REQ, WAIT).
- Reset mid-WAIT: the outstanding response arriving after reset is ignored (state IDLE/REQ does not sample rvalid).
- imem_addr[1:0] is passed through unchecked.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - Adds output ports perf_redirects[31:0] and perf_squashed[31:0].
  - perf_redirects increments on each cycle with redirect.
  - perf_squashed increments on each discarded rvalid or dropped hold entry.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg holds:
  - pc_sel_t enum (PC_PLUS4=2'b00, PC_JALR=2'b01, PC_BRANCH=2'b10, PC_JAL=2'b11).
  - fetch_state_t enum (IDLE, REQ, WAIT, HOLD).
  - JALR/JAL/BRANCH opcode constants, shared with the hazard unit.
- Sub-module if_de_pipe_reg: valid/pc/pc4/ir register with stall/flush/load inputs.

Test Plan:
- Reset, then gnt immediate and rvalid 1 cycle later with rdata 32'h00000013 -> if_de_pc=0, if_de_ir=32'h13, then next imem_addr=4.
- In WAIT at pc=8, pc_sel=10 with branch_pc=32'h40, rvalid 2 cycles later -> response discarded, if_de_valid stays 0, next imem_addr=32'h40.
- pc_sel=11 and rvalid in the same cycle, jal_pc=32'h100 -> no IF/DE load, imem_addr=32'h100 next REQ.
- stall=1 for 3 cycles while rvalid returns at pc=12 -> HOLD, IF/DE frozen; on stall release if_de_pc=12, then fetch 16.
- flush=1 with stall=1 -> if_de_valid=0 next cycle, and the hold entry survives unless pc_sel!=0.
- pc=32'hFFFF_FFFC fetch completes -> next imem_addr=0 (wrap). Under FETCH_PERF_EN, perf_redirects increments by 1 per redirect cycle.
